// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle divider: FSM encodings, iteration count
// and the ALU op codes that route DIV/DIVU to this block.
package div_ctrl_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic [7:0] ALU_OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] ALU_OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] ALU_OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] ALU_OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] ALU_OP_DIVU  = 8'b0001_1011;

endpackage

// File: rtl/div_ctrl_if.sv
// EX <-> divider handshake: operands and start/annul in, {remainder, quotient},
// ready and the pipeline stall request out.
interface div_ctrl_if
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
);
  logic                  signed_div;
  logic [DATA_W-1:0]     opdata1;
  logic [DATA_W-1:0]     opdata2;
  logic                  start;
  logic                  annul;
  logic [2*DATA_W-1:0]   result;
  logic                  ready;
  logic                  stall_req;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready, stall_req
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready, stall_req
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// subtract the divisor, keep the difference only when it does not borrow.
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              dividend_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              quot_bit
);
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // The shifted remainder carries one extra bit so divisors >= 2^(DATA_W-1)
  // cannot lose the top bit before the compare.
  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    quot_bit = ~diff[DATA_W];
    rem_next = quot_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  end
endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned divider for DIV/DIVU: sequencing FSM, iteration
// counter, operand magnitude capture and final sign correction.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_CYCLES,
  parameter int unsigned CNT_W  = 6
) (
  input  logic      clk,
  input  logic      rst,
  div_ctrl_if.slave bus
);
  div_state_e            state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [DATA_W-1:0]     quot, quot_n;
  logic [DATA_W-1:0]     rem, rem_n;
  logic [DATA_W-1:0]     divisor, divisor_n;
  logic                  neg_q, neg_q_n;
  logic                  neg_r, neg_r_n;
  logic                  ready_q, ready_n;
  logic [2*DATA_W-1:0]   result_q, result_n;

  logic [DATA_W-1:0]     op1_abs, op2_abs;
  logic [DATA_W-1:0]     step_rem;
  logic                  step_qbit;

  assign op1_abs = (bus.signed_div && bus.opdata1[DATA_W-1]) ? -bus.opdata1 : bus.opdata1;
  assign op2_abs = (bus.signed_div && bus.opdata2[DATA_W-1]) ? -bus.opdata2 : bus.opdata2;

  // quot doubles as the dividend shift register: its MSB feeds each step while
  // the new quotient bit enters at the LSB.
  div_step #(.DATA_W(DATA_W)) u_step (
    .rem          (rem),
    .dividend_bit (quot[DATA_W-1]),
    .divisor      (divisor),
    .rem_next     (step_rem),
    .quot_bit     (step_qbit)
  );

  assign bus.ready     = ready_q;
  assign bus.result    = result_q;
  assign bus.stall_req = bus.start & ~ready_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      quot     <= '0;
      rem      <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      quot     <= quot_n;
      rem      <= rem_n;
      divisor  <= divisor_n;
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
      ready_q  <= ready_n;
      result_q <= result_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    quot_n    = quot;
    rem_n     = rem;
    divisor_n = divisor;
    neg_q_n   = neg_q;
    neg_r_n   = neg_r;
    ready_n   = ready_q;
    result_n  = result_q;

    unique case (state)
      DIV_FREE: begin
        if (bus.start && !bus.annul) begin
          if (bus.opdata2 == '0) begin
            state_n = DIV_BYZERO;
          end else begin
            state_n   = DIV_ON;
            cnt_n     = '0;
            rem_n     = '0;
            quot_n    = op1_abs;
            divisor_n = op2_abs;
            neg_q_n   = bus.signed_div & (bus.opdata1[DATA_W-1] ^ bus.opdata2[DATA_W-1]);
            neg_r_n   = bus.signed_div & bus.opdata1[DATA_W-1];
          end
        end
      end

      DIV_BYZERO: begin
        if (bus.annul) begin
          state_n = DIV_FREE;
        end else begin
          state_n = DIV_END;
          quot_n  = '0;
          rem_n   = '0;
          neg_q_n = 1'b0;
          neg_r_n = 1'b0;
        end
      end

      DIV_ON: begin
        if (bus.annul) begin
          state_n = DIV_FREE;
          cnt_n   = '0;
        end else begin
          rem_n  = step_rem;
          quot_n = {quot[DATA_W-2:0], step_qbit};
          cnt_n  = cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state_n = DIV_END;
        end
      end

      DIV_END: begin
        if (bus.annul || !bus.start) begin
          state_n  = DIV_FREE;
          ready_n  = 1'b0;
          result_n = '0;
        end else begin
          ready_n  = 1'b1;
          result_n = {(neg_r ? -rem : rem), (neg_q ? -quot : quot)};
        end
      end

      default: state_n = DIV_FREE;
    endcase
  end
endmodule

// File: tb/tb_div_ctrl.sv
// Directed-vector bench for div_ctrl: latency, signed/unsigned results, divide by
// zero, annul, mid-division reset and result hold while start stays high.
module tb_div_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  div_ctrl_if #(.DATA_W(32)) bus ();

  div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.signed_div = s;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.start      = 1'b1;
    #1;
  endtask

  // Waits for ready (first edge counted is the capture edge), checks latency,
  // stall behaviour and result, optionally holds start, then releases it.
  task automatic finish_div(input string tag, input logic [31:0] exp_q, input logic [31:0] exp_r,
                            input int exp_lat, input bit scramble, input int hold);
    int n;
    bit stall_ok;
    n = 0;
    stall_ok = 1'b1;
    while (bus.ready !== 1'b1 && n < 100) begin
      if (bus.stall_req !== 1'b1) stall_ok = 1'b0;
      tick();
      n++;
      if (scramble && n == 1) begin
        bus.opdata1    = 32'h1234_5678;
        bus.opdata2    = 32'h0;
        bus.signed_div = ~bus.signed_div;
      end
    end
    check({tag, " latency"}, 64'(n - 1), 64'(exp_lat));
    check({tag, " stall_before_ready"}, 64'(stall_ok), 64'd1);
    check({tag, " result"}, bus.result, {exp_r, exp_q});
    check({tag, " stall_at_ready"}, 64'(bus.stall_req), 64'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold_ready"}, 64'(bus.ready), 64'd1);
      check({tag, " hold_result"}, bus.result, {exp_r, exp_q});
    end
    bus.start = 1'b0;
    tick();
    check({tag, " ready_drop"}, 64'(bus.ready), 64'd0);
    check({tag, " result_clear"}, bus.result, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.annul      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    rst = 1'b0;
    tick();
    tick();
    check("reset ready", 64'(bus.ready), 64'd0);
    check("reset result", bus.result, 64'd0);
    check("reset stall", 64'(bus.stall_req), 64'd0);
    rst = 1'b1;
    tick();

    launch(1'b0, 32'd100, 32'd7);
    finish_div("divu_100_7", 32'd14, 32'd2, 33, 1'b0, 0);

    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    finish_div("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0, 0);

    launch(1'b0, 32'hFFFF_FFF9, 32'd2);
    finish_div("divu_fff9_2", 32'h7FFF_FFFC, 32'd1, 33, 1'b0, 0);

    launch(1'b1, 32'd7, 32'hFFFF_FFFE);
    finish_div("div_7_m2", 32'hFFFF_FFFD, 32'd1, 33, 1'b0, 0);

    launch(1'b0, 32'hFFFF_FFFF, 32'h8000_0001);
    finish_div("divu_big_divisor", 32'd1, 32'h7FFF_FFFE, 33, 1'b0, 0);

    launch(1'b0, 32'd55, 32'd0);
    finish_div("div_by_zero", 32'd0, 32'd0, 2, 1'b0, 0);

    // Annul after ten steps, then restart with operands scrambled after capture.
    launch(1'b0, 32'd1000, 32'd3);
    tick();
    repeat (10) tick();
    bus.annul = 1'b1;
    tick();
    check("annul ready", 64'(bus.ready), 64'd0);
    check("annul stall_with_start", 64'(bus.stall_req), 64'd1);
    repeat (3) begin
      tick();
      check("annul held ready", 64'(bus.ready), 64'd0);
    end
    bus.start = 1'b0;
    bus.annul = 1'b0;
    #1;
    check("annul stall_drop", 64'(bus.stall_req), 64'd0);
    tick();
    check("annul ready_idle", 64'(bus.ready), 64'd0);
    launch(1'b0, 32'd9, 32'd3);
    finish_div("restart_9_3", 32'd3, 32'd0, 33, 1'b1, 0);

    // start with annul in FREE must not begin a division.
    launch(1'b0, 32'd20, 32'd4);
    bus.annul = 1'b1;
    repeat (3) begin
      tick();
      check("start_annul ready", 64'(bus.ready), 64'd0);
    end
    bus.annul = 1'b0;
    finish_div("after_annul_20_4", 32'd5, 32'd0, 33, 1'b0, 0);

    // Reset mid-division.
    launch(1'b0, 32'd100, 32'd7);
    tick();
    repeat (20) tick();
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    check("midreset ready", 64'(bus.ready), 64'd0);
    check("midreset result", bus.result, 64'd0);
    check("midreset stall", 64'(bus.stall_req), 64'd0);
    rst = 1'b1;
    tick();
    launch(1'b0, 32'd100, 32'd7);
    finish_div("post_reset_100_7", 32'd14, 32'd2, 33, 1'b0, 0);

    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_div("div_min_m1", 32'h8000_0000, 32'd0, 33, 1'b0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
